// File: rtl/seg_pkg.sv
// Shared types and arithmetic helpers for the inertial front end and the PID block.
// Holds the integrator state encoding, fusion constants and the 27-bit saturator.
package seg_pkg;

   typedef enum logic {CAL, RUN} integ_state_t;

   localparam int ACC_GAIN    = 327;
   localparam int FUSION_STEP = 1024;

   // Clamp a wide signed value into the 27-bit signed integrator range.
   function automatic logic signed [26:0] sat27(input logic signed [31:0] x);
      if (x > 32'sd67108863) begin
         return 27'sh3FFFFFF;
      end else if (x < -32'sd67108864) begin
         return 27'sh4000000;
      end else begin
         return x[26:0];
      end
   endfunction

endpackage

// File: rtl/inertial_integrator_if.sv
// Sensor-sample input and fused-attitude output bundle of the inertial integrator.
// The master modport is the sensor/consumer side, the slave modport is the integrator.
interface inertial_integrator_if;

   logic               vld_in;
   logic signed [15:0] ptch_rt_raw;
   logic signed [15:0] AZ;
   logic               cal_req;
   logic signed [15:0] ptch;
   logic signed [15:0] ptch_rt;
   logic               vld;
   logic               cal_done;

   modport master (
      output vld_in, ptch_rt_raw, AZ, cal_req,
      input  ptch, ptch_rt, vld, cal_done
   );

   modport slave (
      input  vld_in, ptch_rt_raw, AZ, cal_req,
      output ptch, ptch_rt, vld, cal_done
   );

endinterface

// File: rtl/inertial_integrator_rt_offset_cal.sv
// Pitch-rate bias calibration: averages 2^LOG2N raw samples into ptch_rt_off.
// Owns the CAL/RUN state; cal_done is high while in RUN.
module rt_offset_cal
   import seg_pkg::*;
#(
   parameter bit          FAST_SIM     = 1'b0,
   parameter logic [15:0] PTCH_RT_DFLT = 16'h0050
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               vld_in,
   input  logic               cal_req,
   input  logic signed [15:0] ptch_rt_raw,
   output logic signed [15:0] ptch_rt_off,
   output logic               cal_done
);

   localparam int         LOG2N = FAST_SIM ? 4 : 8;
   localparam logic [7:0] LAST  = 8'((1 << LOG2N) - 1);

   integ_state_t       r_state, w_state_next;
   logic signed [23:0] r_acc, w_acc_next, w_acc_sum;
   logic [7:0]         r_cnt, w_cnt_next;
   logic signed [15:0] r_off, w_off_next;

   assign w_acc_sum = r_acc + {{8{ptch_rt_raw[15]}}, ptch_rt_raw};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= CAL;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_off   <= PTCH_RT_DFLT;
      end else begin
         r_state <= w_state_next;
         r_acc   <= w_acc_next;
         r_cnt   <= w_cnt_next;
         r_off   <= w_off_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_acc_next   = r_acc;
      w_cnt_next   = r_cnt;
      w_off_next   = r_off;
      if (cal_req) begin
         // A colliding sample is dropped; the offset survives recalibration start.
         w_state_next = CAL;
         w_acc_next   = '0;
         w_cnt_next   = '0;
      end else if (r_state == CAL && vld_in) begin
         w_acc_next = w_acc_sum;
         w_cnt_next = r_cnt + 8'd1;
         if (r_cnt == LAST) begin
            w_off_next   = w_acc_sum[LOG2N +: 16];
            w_state_next = RUN;
         end
      end
   end

   assign ptch_rt_off = r_off;
   assign cal_done    = (r_state == RUN);

endmodule

// File: rtl/inertial_integrator.sv
// Bias-compensated pitch-rate integrator with complementary accelerometer fusion.
// Produces ptch/ptch_rt with a one-cycle vld strobe, one clock after each accepted sample.
module inertial_integrator
   import seg_pkg::*;
#(
   parameter bit          FAST_SIM     = 1'b0,
   parameter logic [15:0] AZ_OFFSET    = 16'h00A0,
   parameter logic [15:0] PTCH_RT_DFLT = 16'h0050
) (
   input logic            clk,
   input logic            rst,
   inertial_integrator_if.slave bus
);

   logic signed [15:0] w_off;
   logic               w_run;
   logic signed [16:0] w_rt_diff;
   logic signed [15:0] w_rt_comp;
   logic signed [15:0] w_az_comp;
   logic signed [15:0] w_ptch_acc;
   logic signed [15:0] w_ptch;
   logic signed [15:0] w_fus;
   logic signed [31:0] w_int_sum;

   logic signed [26:0] r_ptch_int;
   logic signed [15:0] r_ptch_rt;
   logic               r_vld;

   rt_offset_cal #(
      .FAST_SIM     (FAST_SIM),
      .PTCH_RT_DFLT (PTCH_RT_DFLT)
   ) u_cal (
      .clk         (clk),
      .rst         (rst),
      .vld_in      (bus.vld_in),
      .cal_req     (bus.cal_req),
      .ptch_rt_raw (bus.ptch_rt_raw),
      .ptch_rt_off (w_off),
      .cal_done    (w_run)
   );

   assign w_rt_diff = {bus.ptch_rt_raw[15], bus.ptch_rt_raw} - {w_off[15], w_off};

   always_comb begin
      w_rt_comp = w_rt_diff[15:0];
      if (w_rt_diff[16] != w_rt_diff[15]) begin
         w_rt_comp = w_rt_diff[16] ? 16'sh8000 : 16'sh7FFF;
      end
   end

   // Accelerometer pitch estimate: product bits [25:13], which always fit 13 bits.
   assign w_az_comp  = bus.AZ - AZ_OFFSET;
   assign w_ptch_acc = 16'((w_az_comp * ACC_GAIN) >>> 13);
   assign w_ptch     = r_ptch_int[26:11];
   assign w_fus      = (w_ptch_acc > w_ptch) ? 16'(FUSION_STEP) : 16'(-FUSION_STEP);
   assign w_int_sum  = 32'(r_ptch_int) - 32'(w_rt_comp) + 32'(w_fus);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptch_int <= '0;
         r_ptch_rt  <= '0;
         r_vld      <= 1'b0;
      end else if (bus.cal_req) begin
         r_ptch_int <= '0;
         r_vld      <= 1'b0;
      end else if (bus.vld_in && w_run) begin
         r_ptch_int <= sat27(w_int_sum);
         r_ptch_rt  <= w_rt_comp;
         r_vld      <= 1'b1;
      end else begin
         r_vld      <= 1'b0;
      end
   end

   assign bus.ptch     = r_ptch_int[26:11];
   assign bus.ptch_rt  = r_ptch_rt;
   assign bus.vld      = r_vld;
   assign bus.cal_done = w_run;

endmodule

// File: tb/tb_inertial_integrator.sv
// Self-checking bench for inertial_integrator: directed calibration/integration/fusion
// scenarios plus randomized traffic, compared each cycle against an integer reference model.
module tb_inertial_integrator;

   localparam logic [15:0] AZ_OFF  = 16'h00A0;
   localparam logic [15:0] RT_DFLT = 16'h0050;
   localparam int          N_CAL   = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   inertial_integrator_if bus();

   inertial_integrator #(
      .FAST_SIM     (1'b1),
      .AZ_OFFSET    (AZ_OFF),
      .PTCH_RT_DFLT (RT_DFLT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // reference model state, plain integers
   bit m_run;
   int m_acc, m_cnt, m_off, m_int, m_rt;
   bit m_vld;

   function automatic int s16(input logic [15:0] v);
      return int'($signed(v));
   endfunction

   function automatic int clamp(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 1'b0; m_acc = 0; m_cnt = 0; m_off = s16(RT_DFLT);
      m_int = 0; m_rt = 0; m_vld = 1'b0;
   endtask

   task automatic model_clock(input bit vin, input logic [15:0] raw,
                              input logic [15:0] az, input bit creq);
      int rt, azc, pacc, fus;
      if (creq) begin
         m_run = 1'b0; m_acc = 0; m_cnt = 0; m_int = 0; m_vld = 1'b0;
      end else if (!vin) begin
         m_vld = 1'b0;
      end else if (!m_run) begin
         m_acc += s16(raw);
         m_cnt++;
         m_vld = 1'b0;
         if (m_cnt == N_CAL) begin
            m_off = s16(16'(m_acc >>> $clog2(N_CAL)));
            m_run = 1'b1;
         end
      end else begin
         rt   = clamp(s16(raw) - m_off, -32768, 32767);
         azc  = s16(az - AZ_OFF);
         pacc = (azc * 327) >>> 13;
         fus  = (pacc > (m_int >>> 11)) ? 1024 : -1024;
         m_int = clamp(m_int - rt + fus, -(1 << 26), (1 << 26) - 1);
         m_rt  = rt;
         m_vld = 1'b1;
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [15:0] e_ptch, e_rt;
      e_ptch = 16'(m_int >>> 11);
      e_rt   = 16'(m_rt);
      chk({tag, ".ptch"},     {16'h0, bus.ptch},     {16'h0, e_ptch});
      chk({tag, ".ptch_rt"},  {16'h0, bus.ptch_rt},  {16'h0, e_rt});
      chk({tag, ".vld"},      {31'h0, bus.vld},      {31'h0, m_vld});
      chk({tag, ".cal_done"}, {31'h0, bus.cal_done}, {31'h0, m_run});
   endtask

   task automatic step(input bit vin, input logic [15:0] raw, input logic [15:0] az,
                       input bit creq, input string tag);
      bus.vld_in = vin; bus.ptch_rt_raw = raw; bus.AZ = az; bus.cal_req = creq;
      @(posedge clk);
      model_clock(vin, raw, az, creq);
      #1;
      $display("%0t %s vin=%0b raw=%h az=%h cr=%0b -> ptch=%h rt=%h vld=%0b cd=%0b",
               $time, tag, vin, raw, az, creq, bus.ptch, bus.ptch_rt, bus.vld, bus.cal_done);
      check_outputs(tag);
   endtask

   initial begin
      bus.vld_in = 1'b0; bus.ptch_rt_raw = '0; bus.AZ = '0; bus.cal_req = 1'b0;
      rst = 1'b1;
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      check_outputs("reset");
      rst = 1'b0;

      // calibration to 0x0070, then steady zero-rate hold
      for (int i = 0; i < N_CAL; i++) step(1'b1, 16'h0070, AZ_OFF, 1'b0, "cal");
      chk("cal_done16", {31'h0, bus.cal_done}, 32'd1);
      for (int i = 0; i < 20; i++) step(1'b1, 16'h0070, AZ_OFF, 1'b0, "hold");
      chk("hold_rt_zero", {16'h0, bus.ptch_rt}, 32'h0);

      // rate integration
      for (int i = 0; i < 10; i++) step(1'b1, 16'hE070, AZ_OFF, 1'b0, "rate");
      chk("rate_ptch", {16'h0, bus.ptch}, 32'h0023);
      chk("rate_rt", {16'h0, bus.ptch_rt}, 32'hE000);

      // fusion convergence toward ptch_acc = 0x00A3
      for (int i = 0; i < 400; i++) step(1'b1, 16'h0070, 16'h10A0, 1'b0, "fuse");
      chk("fuse_range", {31'h0, (bus.ptch >= 16'sh00A2) && (bus.ptch <= 16'sh00A4)}, 32'd1);

      // randomized traffic with gaps and occasional recalibration
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom),
              $urandom_range(0, 49) == 0, "rand");
      end

      // recalibrate to 0x0050, then drive rate saturation
      step(1'b0, 16'h0, AZ_OFF, 1'b1, "recal");
      for (int i = 0; i < N_CAL; i++) step(1'b1, 16'h0050, AZ_OFF, 1'b0, "cal50");
      for (int i = 0; i < 2300; i++) step(1'b1, 16'h8000, AZ_OFF, 1'b0, "sat");
      chk("sat_rt", {16'h0, bus.ptch_rt}, 32'h8000);
      chk("sat_ptch", {16'h0, bus.ptch}, 32'h7FFF);

      // cal_req colliding with vld_in during RUN
      step(1'b1, 16'h1234, AZ_OFF, 1'b1, "collide");
      chk("collide_ptch", {16'h0, bus.ptch}, 32'h0);
      chk("collide_cd", {31'h0, bus.cal_done}, 32'd0);
      for (int i = 0; i < N_CAL - 1; i++) step(1'b1, 16'h0070, AZ_OFF, 1'b0, "recal15");
      chk("recal15_cd", {31'h0, bus.cal_done}, 32'd0);
      step(1'b1, 16'h0070, AZ_OFF, 1'b0, "recal16");
      chk("recal16_cd", {31'h0, bus.cal_done}, 32'd1);

      // asynchronous reset in the middle of RUN
      for (int i = 0; i < 3; i++) step(1'b1, 16'h0170, 16'h20A0, 1'b0, "prerst");
      #3 rst = 1'b1;
      #1;
      model_reset();
      chk("async_ptch", {16'h0, bus.ptch}, 32'h0);
      chk("async_rt", {16'h0, bus.ptch_rt}, 32'h0);
      chk("async_vld", {31'h0, bus.vld}, 32'd0);
      chk("async_cd", {31'h0, bus.cal_done}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < N_CAL - 1; i++) step(1'b1, 16'h0030, AZ_OFF, 1'b0, "postrst");
      chk("postrst_cd", {31'h0, bus.cal_done}, 32'd0);
      step(1'b1, 16'h0030, AZ_OFF, 1'b0, "postrst16");
      step(1'b1, 16'h0030, AZ_OFF, 1'b0, "postrun");
      chk("postrun_vld", {31'h0, bus.vld}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/inertial_integrator.md
# inertial_integrator

Upstream stage of the PID block. Takes raw pitch-rate and vertical-acceleration samples from the inertial sensor interface and calibrates out the pitch-rate bias. It then integrates the compensated rate into a pitch angle, using complementary fusion against an accelerometer-derived pitch. Outputs `ptch`, `ptch_rt` and a one-cycle `vld` strobe in exactly the form the PID block consumes.

## Interface

Parameters:
- `FAST_SIM`, default 0. When 1, calibration averages 2^4 samples instead of 2^8.
- `AZ_OFFSET`, default 16'h00A0. Static accelerometer bias.
- `PTCH_RT_DFLT`, default 16'h0050. Rate offset used before the first calibration completes.

Ports:
- `clk`: input, 1. System clock.
- `rst`: input, 1. Asynchronous, active-high reset.
- `vld_in`: input, 1. One new sensor sample is present this cycle.
- `ptch_rt_raw`: input, 16. Signed raw pitch rate.
- `AZ`: input, 16. Signed raw vertical acceleration.
- `cal_req`: input, 1. Pulse; restarts offset calibration.
- `ptch`: output, 16. Signed fused pitch.
- `ptch_rt`: output, 16. Signed offset-compensated pitch rate.
- `vld`: output, 1. `ptch` and `ptch_rt` updated this cycle.
- `cal_done`: output, 1. High while in RUN.

## Operation

- States: CAL and RUN. Reset enters CAL. `cal_req` forces CAL from either state.
- Entering CAL, whether from reset or from `cal_req`, does the following:
  - clears the sample accumulator and sample counter;
  - clears `ptch_int`;
  - leaves `ptch_rt_off` unchanged (reset loads `PTCH_RT_DFLT`).
- CAL behaviour:
  - Each `vld_in` adds sign-extended `ptch_rt_raw` to a 24-bit signed accumulator and increments the counter.
  - On the N-th sample (N = 16 if `FAST_SIM`, else 256), `ptch_rt_off` is set to accumulator >>> log2(N), arithmetic shift and truncate. The state moves to RUN.
  - `vld` stays 0 throughout CAL, and `ptch`/`ptch_rt` hold their values.
- RUN, on each `vld_in`, in this order:
  1. `rt_comp` = `ptch_rt_raw` − `ptch_rt_off`, computed at 17 bits and saturated to 16 bits (0x8000..0x7FFF).
  2. `az_comp` = `AZ` − `AZ_OFFSET`, computed at 16 bits with wrap.
  3. `ptch_acc` = (`az_comp` × 327)[25:13], signed and sign-extended to 16 bits.
  4. `fus` = +1024 if `ptch_acc` > current `ptch` (signed compare), else −1024.
  5. `ptch_int` (27-bit signed) = sat27(`ptch_int` − `rt_comp` + `fus`).
  6. `ptch` takes the new `ptch_int`[26:11]. `ptch_rt` takes `rt_comp`. `vld` = 1.
- `cal_req` and `vld_in` in the same cycle: `cal_req` wins, and that sample is discarded (not accumulated, not integrated).
- `vld_in` is ignored in no state other than the `cal_req` collision above.

## Timing

- Reset values:
  - `ptch`, `ptch_rt`, `ptch_int`, accumulator, counter: 0.
  - `vld`, `cal_done`: 0.
  - `ptch_rt_off`: `PTCH_RT_DFLT`.
  - State: CAL.
- All outputs are registered. Latency is one clock: a `vld_in` sampled at edge k produces updated `ptch`/`ptch_rt` and `vld` = 1 after edge k. `vld` is high for exactly one cycle per accepted sample.
- `cal_done` rises on the same edge that captures the N-th calibration sample. The first RUN `vld` comes from the next accepted sample.
- Back-to-back `vld_in` (every cycle) is supported with no stalls.
- `rst` asserted mid-RUN returns to CAL immediately, with all values at their reset values.

## Structure

- Shared package `seg_pkg` holds:
  - `typedef enum logic {CAL, RUN} integ_state_t`;
  - `ACC_GAIN` = 327;
  - `FUSION_STEP` = 1024;
  - a 27-bit saturate function, also usable by the PID block.
- Sub-module `rt_offset_cal` is natural here. It contains the accumulator, counter and offset register, and outputs `ptch_rt_off` and `cal_done`. The top level holds the fusion datapath and the integrator.

## Test plan

1. **Reset.** Assert `rst` mid-stream → all outputs 0 immediately; `cal_done` = 0; no `vld` for the next 15 `vld_in` pulses (`FAST_SIM` = 1).
2. **Calibration.** `FAST_SIM` = 1; 16 `vld_in` pulses with `ptch_rt_raw` = 0x0070 → `cal_done` rises at the 16th edge and `ptch_rt_off` = 0x0070. Then feed raw = 0x0070 with `AZ` = `AZ_OFFSET` → `ptch_rt` = 0x0000, and `ptch` alternates 0x0000 / 0xFFFF.
3. **Rate integration.** After calibration (offset 0x0070), feed raw = 0x0070 − 0x2000 with `AZ` = `AZ_OFFSET` for 10 samples → `ptch_rt` = 0xE000 and `ptch` = 0x0023.
4. **Fusion convergence.** `az_comp` = 0x1000, rate compensated to 0 → `ptch_acc` = 0x00A3; after 400 samples, `ptch` lies in [0x00A2, 0x00A4].
5. **Saturation.** Offset 0x0050, raw = 0x8000 → `ptch_rt` = 0x8000. Sustain the input → `ptch_int` saturates and `ptch` holds at 0x7FFF, with no wrap.
6. **`cal_req` collision.** `cal_req` and `vld_in` in the same cycle during RUN → `ptch` = 0, `cal_done` = 0, and the colliding sample is not counted: exactly 16 further samples are needed before `cal_done` rises.
